// File: rtl/spi_pkg.sv
// spi_pkg: FSM states and MODE encodings shared by the SPI master
package spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;
  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;
  localparam logic [1:0] MODE0 = 2'd0;
  localparam logic [1:0] MODE1 = 2'd1;
  localparam logic [1:0] MODE2 = 2'd2;
  localparam logic [1:0] MODE3 = 2'd3;
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period tick every CLK_DIV cycles while enabled, restarting when en rises
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (!en || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign tick = en && cnt_q == LAST;
endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: single-transfer SPI master with programmable CPOL/CPHA and registered pin outputs
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        MODE,
  input  logic [DATA_W-1:0] DATA,
  output logic [DATA_W-1:0] OUT,
  output logic              busy,
  output logic              done,
  output logic              SS,
  output logic              SCK,
  output logic              MOSI,
  input  logic              MISO
);
  localparam int HW = $clog2(2 * DATA_W + 1);
  localparam logic [HW-1:0] H_LAST = HW'(2 * DATA_W - 1);
  state_e state_q, state_d;
  logic tick, tick_q, div_en;
  logic [HW-1:0] h_q, h_d;
  logic [1:0] mode_q, mode_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, out_q, out_d;
  logic busy_q, busy_d, done_q, done_d, ss_q, ss_d, sck_q, sck_d, mosi_q, mosi_d;
  logic accept, first, lead, sample, adv;
  assign div_en = state_q != IDLE;
  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk (clk),
    .rst (rst),
    .en  (div_en),
    .tick(tick)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      h_q     <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      tick_q  <= tick;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? SETUP : IDLE;
      SETUP:   state_d = tick ? SHIFT : SETUP;
      SHIFT:   state_d = (tick && h_q == H_LAST) ? HOLD : SHIFT;
      HOLD:    state_d = tick ? GAP : HOLD;
      GAP:     state_d = tick ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
    h_d = (state_q == SHIFT) ? h_q + HW'(tick) : '0;
  end
  always_comb begin
    accept = state_q == IDLE && start;
    first  = tick_q && state_q == SHIFT;
    lead   = !h_q[0];
    sample = first && (lead ^ mode_q[CPHA_BIT]);
    adv    = first && (mode_q[CPHA_BIT] ? (lead && h_q != '0) : (!lead && h_q != H_LAST));
    mode_d = accept ? MODE : mode_q;
    tx_d   = accept ? DATA : adv ? tx_q << 1 : tx_q;
    rx_d   = sample ? {rx_q[DATA_W-2:0], MISO} : rx_q;
    ss_d   = state_q == IDLE || state_q == GAP;
    busy_d = state_q != IDLE;
    sck_d  = state_q == IDLE ? MODE[CPOL_BIT] : state_q == SETUP ? mode_q[CPOL_BIT] : first ? !sck_q : sck_q;
    mosi_d = state_q == SETUP ? tx_q[DATA_W-1] : adv ? tx_q[DATA_W-2] : mosi_q;
    done_d = state_q == GAP && tick_q;
    out_d  = done_d ? rx_q : out_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
      out_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ss_q   <= 1'b1;
      sck_q  <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      out_q  <= out_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ss_q   <= ss_d;
      sck_q  <= sck_d;
      mosi_q <= mosi_d;
    end
  end
  assign OUT  = out_q;
  assign busy = busy_q;
  assign done = done_q;
  assign SS   = ss_q;
  assign SCK  = sck_q;
  assign MOSI = mosi_q;
endmodule
